// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, blank code and FSM states for the seven-segment decoder
package seg7_pkg;
  typedef enum logic {SETTLE, LOCKED} state_t;
  localparam logic [6:0] BLANK_CODE = 7'h00;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_glyph_lut.sv
// seg7_glyph_lut: combinational segment-pattern to hex digit classifier
module seg7_glyph_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid,
  output logic       blank,
  output logic       illegal
);
  always_comb begin
    digit = '0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pattern == GLYPHS[i]) begin
        digit = 4'(i);
        valid = 1'b1;
      end
    blank = pattern == BLANK_CODE;
    illegal = !valid && !blank;
  end
endmodule

// File: rtl/seg7_decode.sv
// seg7_decode: debounced seven-segment observer; change counter enabled by SEG7_DECODE_COUNT_EN
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       illegal,
  output logic       new_digit,
  output logic [7:0] change_count
);
  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  logic [6:0] sync1, seg_s, seg_p, stored;
  logic       have;
  logic [3:0] cnt;
  state_t     state, state_n;
  logic       changed, accept, pulse;
  logic [3:0] lut_digit;
  logic       lut_valid, lut_blank, lut_illegal;
  seg7_glyph_lut u_lut (
    .pattern(seg_s),
    .digit  (lut_digit),
    .valid  (lut_valid),
    .blank  (lut_blank),
    .illegal(lut_illegal)
  );
  always_comb begin
    changed = seg_s != seg_p;
    accept = state == SETTLE && !changed && cnt == SC - 4'd1;
    pulse = accept && (!have || seg_s != stored);
    state_n = changed ? SETTLE : accept ? LOCKED : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      seg_s <= '0;
      seg_p <= '0;
      cnt <= '0;
      state <= SETTLE;
      stored <= '0;
      have <= 1'b0;
      digit <= '0;
      digit_valid <= 1'b0;
      blank <= 1'b0;
      illegal <= 1'b0;
      new_digit <= 1'b0;
    end else begin
      sync1 <= segments_in;
      seg_s <= sync1;
      seg_p <= seg_s;
      cnt <= changed ? '0 : cnt == SC ? cnt : cnt + 4'd1;
      state <= state_n;
      new_digit <= pulse;
      if (accept) begin
        stored <= seg_s;
        have <= 1'b1;
        digit_valid <= lut_valid;
        blank <= lut_blank;
        illegal <= lut_illegal;
        if (lut_valid) digit <= lut_digit;
      end
    end
  end
`ifdef SEG7_DECODE_COUNT_EN
  // counts alongside the pulse so both appear after the same edge
  always_ff @(posedge clk) begin
    if (rst) change_count <= '0;
    else if (pulse) change_count <= change_count + 8'd1;
  end
`else
  assign change_count = '0;
`endif
endmodule

// File: tb/tb_seg7_decode.sv
// tb_seg7_decode: randomized and directed checks of seg7_decode against a sample-history model
module tb_seg7_decode;
  localparam int S = 4;
`ifdef SEG7_DECODE_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segments_in = 7'h3F;
  logic [3:0] digit;
  logic       digit_valid, blank, illegal, new_digit;
  logic [7:0] change_count;
  always #5 clk = ~clk;
  seg7_decode #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .segments_in (segments_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .illegal     (illegal),
    .new_digit   (new_digit),
    .change_count(change_count)
  );
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Model: a pattern is accepted exactly when a run of identical samples reaches
  // S+1 samples, two edges after its last sample; reset looks like a fresh run of zeros.
  logic [7:0] hist [8192];
  int         e = 8;
  logic [3:0] m_digit = '0;
  logic       m_valid = 1'b0, m_blank = 1'b0, m_ill = 1'b0, m_nd = 1'b0;
  logic [7:0] m_cnt = '0;
  int         m_stored = -1;
  always @(posedge clk) begin
    bit same;
    int idx;
    logic [6:0] v;
    e = e + 1;
    m_nd = 1'b0;
    if (rst) begin
      hist[e] = 8'h00;
      hist[e-1] = 8'h00;
      hist[e-2] = 8'h00;
      hist[e-3] = 8'hFF;
      m_digit = '0;
      m_valid = 1'b0;
      m_blank = 1'b0;
      m_ill = 1'b0;
      m_cnt = '0;
      m_stored = -1;
    end else begin
      hist[e] = {1'b0, segments_in};
      same = 1'b1;
      for (int j = e - S - 2; j < e - 2; j++) if (hist[j] != hist[e-2]) same = 1'b0;
      if (same && hist[e-S-3] != hist[e-2]) begin
        v = hist[e-2][6:0];
        idx = -1;
        for (int j = 0; j < 16; j++) if (v == TBL[j]) idx = j;
        m_valid = idx >= 0;
        m_blank = v == 7'h00;
        m_ill = !m_valid && !m_blank;
        if (m_valid) m_digit = 4'(idx);
        if (int'(v) != m_stored) begin
          m_nd = 1'b1;
          if (CEN) m_cnt = m_cnt + 8'd1;
        end
        m_stored = int'(v);
      end
    end
  end
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("outs", {digit, digit_valid, blank, illegal, new_digit, change_count},
            {m_digit, m_valid, m_blank, m_ill, m_nd, m_cnt});
      if (new_digit) pulses++;
    end
  endtask
  initial begin
    tick(3);
    check("reset_outs", {digit, digit_valid, blank, illegal, new_digit, change_count}, 0);
    rst = 1'b0;
    tick(6);
    check("nd_early", new_digit, 0);
    tick(1);
    check("nd_latency", new_digit, 1);
    check("first_digit", digit, 0);
    check("first_valid", digit_valid, 1);
    check("first_count", change_count, CEN ? 1 : 0);
    segments_in = 7'h06;
    tick(8);
    check("steady_06", digit, 1);
    pulses = 0;
    segments_in = 7'h7F;
    tick(2);
    segments_in = 7'h06;
    tick(10);
    check("glitch_pulses", pulses, 0);
    check("glitch_digit", digit, 1);
    rst = 1'b1;
    segments_in = 7'h3F;
    tick(2);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      segments_in = TBL[i];
      tick(8);
      check("glyph_digit", digit, i);
      check("glyph_valid", digit_valid, 1);
    end
    check("glyph_pulses", pulses, 16);
    check("glyph_count", change_count, CEN ? 16 : 0);
    segments_in = 7'h00;
    tick(8);
    check("blank_flag", blank, 1);
    check("blank_digit", digit, 15);
    check("blank_valid", digit_valid, 0);
    segments_in = 7'h7F;
    tick(8);
    check("eight_digit", digit, 8);
    check("eight_valid", digit_valid, 1);
    segments_in = 7'h01;
    tick(8);
    check("illegal_flag", illegal, 1);
    check("illegal_valid", digit_valid, 0);
    segments_in = 7'h3F;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midsettle_rst", {digit, digit_valid, blank, illegal, new_digit, change_count}, 0);
    rst = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      segments_in = i[0] ? 7'h06 : 7'h3F;
      tick(7);
    end
    check("wrap_pulses", pulses, 256);
    check("wrap_count", change_count, 0);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: segments_in = TBL[$urandom_range(0, 15)];
        2: segments_in = 7'h00;
        default: segments_in = 7'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, 8));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
